mux8_rr_scheduler: RTL and testbench
====================================

Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux (3-bit select, enable, 8-bit data) among 8 requesters.
- Arbitrates the request lines and grants the mux to one requester at a time for a bounded burst of cycles.
- Drives the mux select/enable directly.
- Reports the current owner (one-hot) and a completion pulse per grant.

Parameters:
- HOLD, 4, maximum cycles per grant; legal range 1..255.
- CNT_W, 8, width of the burst down-counter; must satisfy 2^CNT_W > HOLD.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request lines; req[i] high = requester i wants the mux; held high until served or released.
- select  out  3  mux select = index of current owner.
- enable  out  1  mux enable; high only while a grant is active.
- grant  out  8  one-hot owner; all-zero when idle.
- busy  out  1  high while in GRANT state (equals enable).
- done  out  1  one-cycle pulse in the cycle after a grant ends.

Behaviour:
- Reset (async assert, any time, including mid-grant) forces:
  - select=0, enable=0, grant=0, busy=0, done=0
  - state=IDLE, counter=0, last-served pointer=7, so the first search starts at index 0.
- All outputs are registered. There is no combinational path from req to any output.
- States are IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE; enable=0, grant=0.
  - Otherwise, at the clock edge choose idx = first i with req[i]=1, searching (last+1) mod 8 upward with wrap-around.
  - Next cycle: state=GRANT, select=idx, grant=1<<idx, enable=1, busy=1, counter=HOLD-1.
  - Latency: req high before edge k gives enable high in the cycle after edge k.
- GRANT, evaluated at each edge:
  - End condition: counter==0 OR req[idx]==0 (early release). On end:
    - next cycle: state=IDLE, enable=0, grant=0, busy=0, done=1, last=idx.
    - select holds idx; it is not cleared.
  - Otherwise: counter decrements and outputs hold.
  - The counter reaching 0 and req[idx] dropping at the same edge produce one end event and a single done pulse.
  - Changes on the other req bits are ignored during GRANT.
- Resulting timing:
  - enable is high for exactly min(HOLD, cycles req[idx] stays high after the grant starts) cycles, and never more than HOLD.
  - There is a mandatory single IDLE cycle between consecutive grants, during which enable=0 and done=1.
  - Arbitration for the next grant happens in that IDLE cycle. Back-to-back period per requester is therefore HOLD+1 cycles.
- Fairness:
  - The pointer advances only on grant completion.
  - A requester that has just been served has the lowest priority in the next arbitration.
  - With all 8 requesting, service order is 0..7 repeating.
- Invariants:
  - grant is one-hot or zero.
  - enable == busy == (grant != 0).
  - When enable=1, select equals the index of the grant bit.
  - done is never high while enable is high.
- HOLD=1: every grant lasts exactly 1 cycle, followed by 1 IDLE cycle.

Test Plan:
- Reset mid-grant: req=8'h08 and grant active with counter=2; pull rst_n low asynchronously -> outputs go 0 immediately without waiting for clk. After release with req=8'h00: state stays IDLE; with req=8'h01 the next grant is index 0.
- Single requester, HOLD=4: req=8'h08 held -> select=3, enable=1 for 4 cycles, then 1 cycle with enable=0 and done=1, then re-grant select=3. This repeats with period 5.
- All requesting: req=8'hFF held -> grant sequence 01,02,04,...,80,01; each grant 4 cycles enable high plus 1 gap cycle; full rotation 40 cycles. grant is checked one-hot at every cycle.
- Early release: req=8'h20, then drop req[5] after 2 grant cycles -> enable high exactly 2 cycles, done pulses once, last=5; IDLE persists while req=0.
- Wrap-around priority: serve index 6 first, then req=8'h41 -> next grant is index 0 (search 7, wrap to 0), then index 6.
- Simultaneous end: req[2] drops at the same edge the counter hits 0 -> exactly one done pulse, no extra grant cycle. Repeat on a HOLD=1 instance: req=8'h81 -> grants alternate 0 and 7 every 2 cycles.

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of a shared 8:1 single-bit mux: grants one requester at a
// time for at most HOLD cycles, with one idle/arbitration cycle between grants.
module mux8_rr_scheduler #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [2:0] select,
  output logic       enable,
  output logic [7:0] grant,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NREQ = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       last;
  logic [2:0]       pick_c;

  // First requester at or after last+1, wrapping; descending scan lets the nearest win.
  always_comb begin
    pick_c = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[3'(int'(last) + k)]) pick_c = 3'(int'(last) + k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 3'd7;
      select <= '0;
      enable <= 1'b0;
      grant  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req != '0) begin
            state  <= GRANT;
            select <= pick_c;
            grant  <= 8'(1) << pick_c;
            enable <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CNT_W'(HOLD - 1);
          end
        end
        GRANT: begin
          // Burst exhaustion and early release collapse into one end event.
          if (cnt == '0 || !req[select]) begin
            state  <= IDLE;
            enable <= 1'b0;
            grant  <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            last   <= select;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: HOLD=4 and HOLD=1 instances against a
// cycle-level behavioural model, directed scenarios plus random requests.
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;

  logic [2:0] s0, s1;
  logic       e0, e1, b0, b1, d0, d1;
  logic [7:0] g0, g1;

  mux8_rr_scheduler #(.HOLD(4), .CNT_W(8)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .select(s0), .enable(e0), .grant(g0), .busy(b0), .done(d0)
  );

  mux8_rr_scheduler #(.HOLD(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .select(s1), .enable(e1), .grant(g1), .busy(b1), .done(d1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: per instance, whether a grant is active, who owns it, how many
  // cycles it has been high so far, the last finished owner, and done.
  int m_act [2];
  int m_own [2];
  int m_used[2];
  int m_last[2];
  int m_sel [2];
  int m_done[2];

  int en_cnt, dn_cnt;
  logic [7:0] starts[$];
  logic [7:0] rnd;
  logic       prev_en;

  function automatic int hold_of(input int j);
    return (j == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_act[j]  = 0;
      m_own[j]  = 0;
      m_used[j] = 0;
      m_last[j] = 7;
      m_sel[j]  = 0;
      m_done[j] = 0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (m_act[j] != 0) begin
          if (m_used[j] >= hold_of(j) || req[m_own[j]] == 1'b0) begin
            m_act[j]  = 0;
            m_done[j] = 1;
            m_last[j] = m_own[j];
          end else begin
            m_used[j]++;
            m_done[j] = 0;
          end
        end else begin
          m_done[j] = 0;
          if (req != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
              if (m_act[j] == 0 && req[(m_last[j] + k) % 8]) begin
                m_act[j]  = 1;
                m_own[j]  = (m_last[j] + k) % 8;
                m_sel[j]  = m_own[j];
                m_used[j] = 1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic compare_inst(input int j, input logic [2:0] s, input logic e,
                              input logic [7:0] g, input logic b, input logic d);
    logic [7:0] eg;
    eg = (m_act[j] != 0) ? (8'(1) << m_own[j]) : 8'h00;
    chk($sformatf("i%0d_select", j), 32'(s), 32'(m_sel[j]));
    chk($sformatf("i%0d_enable", j), 32'(e), 32'(m_act[j] != 0));
    chk($sformatf("i%0d_grant", j),  32'(g), 32'(eg));
    chk($sformatf("i%0d_busy", j),   32'(b), 32'(e));
    chk($sformatf("i%0d_done", j),   32'(d), 32'(m_done[j] != 0));
    chk($sformatf("i%0d_onehot0", j), 32'($onehot0(g)), 32'(1));
    chk($sformatf("i%0d_done_en", j), 32'(d & e), 32'(0));
  endtask

  task automatic compare_all();
    compare_inst(0, s0, e0, g0, b0, d0);
    compare_inst(1, s1, e1, g1, b1, d1);
  endtask

  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    en_cnt += int'(e0);
    dn_cnt += int'(d0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(8'h00);
    cycle(8'h00);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle(8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    en_cnt = 0;
    dn_cnt = 0;
    model_reset();
    cycle(8'h00);
    cycle(8'h00);
    chk("reset_grant", 32'(g0), 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a grant.
    cycle(8'h08);
    cycle(8'h08);
    chk("pre_rst_select", 32'(s0), 32'd3);
    chk("pre_rst_enable", 32'(e0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_grant", 32'(g0), 32'h0);
    @(negedge clk);
    cycle(8'h00);
    cycle(8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(8'h00);
    chk("post_rst_idle", 32'(e0), 32'd0);
    cycle(8'h01);
    chk("post_rst_first", 32'(g0), 32'h01);
    drain();

    // Single requester: period HOLD+1.
    en_cnt = 0;
    dn_cnt = 0;
    for (int i = 0; i < 10; i++) cycle(8'h08);
    chk("single_en_cycles", 32'(en_cnt), 32'd8);
    chk("single_done_cnt", 32'(dn_cnt), 32'd2);
    chk("single_select", 32'(s0), 32'd3);
    drain();

    // All requesting: strict 0..7 rotation.
    do_reset();
    starts.delete();
    prev_en = 1'b0;
    for (int i = 0; i < 41; i++) begin
      cycle(8'hFF);
      if (e0 && !prev_en) starts.push_back(g0);
      prev_en = e0;
    end
    chk("rot_count", 32'(starts.size()), 32'd9);
    for (int i = 0; i < 9 && i < starts.size(); i++)
      chk($sformatf("rot_grant%0d", i), 32'(starts[i]), 32'(8'(1) << (i % 8)));
    drain();

    // Early release after two grant cycles.
    do_reset();
    en_cnt = 0;
    dn_cnt = 0;
    cycle(8'h20);
    cycle(8'h20);
    for (int i = 0; i < 6; i++) cycle(8'h00);
    chk("early_en_cycles", 32'(en_cnt), 32'd2);
    chk("early_done_cnt", 32'(dn_cnt), 32'd1);

    // Wrap-around: after serving 6, 0 wins before 6.
    do_reset();
    cycle(8'h40);
    for (int i = 0; i < 3; i++) cycle(8'h00);
    cycle(8'h41);
    chk("wrap_first", 32'(g0), 32'h01);
    for (int i = 0; i < 5; i++) cycle(8'h41);
    chk("wrap_second", 32'(g0), 32'h40);
    drain();

    // Counter expiry and release at the same edge.
    do_reset();
    en_cnt = 0;
    dn_cnt = 0;
    for (int i = 0; i < 4; i++) cycle(8'h04);
    cycle(8'h00);
    chk("simul_done", 32'(d0), 32'd1);
    chk("simul_enable", 32'(e0), 32'd0);
    for (int i = 0; i < 3; i++) cycle(8'h00);
    chk("simul_en_cycles", 32'(en_cnt), 32'd4);
    chk("simul_done_cnt", 32'(dn_cnt), 32'd1);

    // HOLD=1 alternation between 0 and 7.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_g;
      cycle(8'h81);
      exp_g = (i % 4 == 0) ? 8'h01 : ((i % 4 == 2) ? 8'h80 : 8'h00);
      chk($sformatf("h1_alt%0d", i), 32'(g1), 32'(exp_g));
    end
    drain();

    // Random request traffic.
    do_reset();
    rnd = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (rnd[b]) begin
          if ($urandom_range(5) == 0) rnd[b] = 1'b0;
        end else begin
          if ($urandom_range(3) == 0) rnd[b] = 1'b1;
        end
      end
      if ($urandom_range(99) == 0) rnd = 8'($urandom);
      cycle(rnd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
